// File: rtl/cache_read_streamer_pkg.sv
// Shared definitions for the cache read streamer: FSM encoding and output buffer depth.
package cache_read_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Entries held by the output buffer; read issue is throttled against this.
    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry output buffer with a bypass path: arriving cache data is presented
// directly when the buffer is empty, and is stored only if not taken at once.
module skid_fifo2
    import cache_read_streamer_pkg::*;
#(
    parameter int C_DATA_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_vld,
    input  logic [C_DATA_WIDTH-1:0] wr_data,
    input  logic                    wr_last,
    input  logic                    rd_rdy,
    output logic                    rd_vld,
    output logic [C_DATA_WIDTH-1:0] rd_data,
    output logic                    rd_last,
    output logic [1:0]              count
);

    logic [C_DATA_WIDTH-1:0] mem_data [BUF_DEPTH];
    logic                    mem_last [BUF_DEPTH];
    logic                    rd_ptr;
    logic                    wr_ptr;
    logic                    empty;
    logic                    bypass;
    logic                    push;
    logic                    pop_mem;

    // Head selection: stored entries always go first so order is preserved.
    always_comb begin
        empty   = (count == 2'd0);
        rd_vld  = !empty || wr_vld;
        rd_data = (empty && wr_vld) ? wr_data : mem_data[rd_ptr];
        rd_last = (empty && wr_vld) ? wr_last : mem_last[rd_ptr];
        bypass  = empty && wr_vld && rd_rdy;
        push    = wr_vld && !bypass;
        pop_mem = !empty && rd_rdy;
    end

    // Storage, pointers and occupancy; data is cleared too so idle output reads zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= wr_data;
                mem_last[wr_ptr] <= wr_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop_mem) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop_mem};
        end
    end

endmodule

// File: rtl/cache_read_streamer.sv
// Streams a burst of cache entries out as valid/ready beats, wrapping the
// address around the cache and never over-issuing reads past the buffer space.
module cache_read_streamer
    import cache_read_streamer_pkg::*;
#(
    parameter int C_DATA_WIDTH    = 128,
    parameter int C_SIZE_OF_CACHE = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_start,
    input  logic [$clog2(C_SIZE_OF_CACHE)-1:0] i_base_addr,
    input  logic [$clog2(C_SIZE_OF_CACHE):0]   i_burst_len,
    output logic [$clog2(C_SIZE_OF_CACHE)-1:0] o_cache_addr,
    output logic                               o_cache_rd_en,
    input  logic [C_DATA_WIDTH-1:0]            i_cache_data,
    input  logic                               i_cache_empty,
    output logic [C_DATA_WIDTH-1:0]            o_data,
    output logic                               o_data_is_valid,
    input  logic                               i_data_ready,
    output logic                               o_last,
    output logic                               o_busy,
    output logic                               o_done
);

    localparam int            AW      = $clog2(C_SIZE_OF_CACHE);
    localparam logic [AW:0]   MAX_LEN = (AW+1)'(C_SIZE_OF_CACHE);

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   addr;
    logic [AW:0]     reads_left;
    logic [AW:0]     len_clamped;
    logic            rd_en;
    logic            last_rd;
    logic            last_acc;
    logic            zero_start;
    logic            done_r;
    logic            rd_vld_p1;
    logic            rd_last_p1;
    logic [1:0]      buf_count;
    logic            fifo_vld;
    logic            fifo_last;

    // Next state, read issue throttle and burst-end detection.
    always_comb begin
        state_nxt   = state;
        len_clamped = (i_burst_len > MAX_LEN) ? MAX_LEN : i_burst_len;
        zero_start  = (state == ST_IDLE) && i_start && (len_clamped == '0);
        rd_en       = (state == ST_FETCH) && (reads_left != '0) && !i_cache_empty
                      && ((buf_count + {1'b0, rd_vld_p1}) < 2'(BUF_DEPTH));
        last_rd     = rd_en && (reads_left == (AW+1)'(1));
        last_acc    = (state == ST_DRAIN) && fifo_vld && i_data_ready && fifo_last;
        case (state)
            ST_IDLE:  if (i_start && (len_clamped != '0)) state_nxt = ST_FETCH;
            ST_FETCH: if (last_rd)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (last_acc) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Address and read counters, done pulse, and the one-cycle read-latency stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr       <= '0;
            reads_left <= '0;
            done_r     <= 1'b0;
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
        end else begin
            done_r <= zero_start || last_acc;
            if ((state == ST_IDLE) && i_start) begin
                addr       <= i_base_addr;
                reads_left <= len_clamped;
            end else if (rd_en) begin
                addr       <= addr + AW'(1);
                reads_left <= reads_left - (AW+1)'(1);
            end
            // p1: cache data for a read issued last cycle is on i_cache_data now
            rd_vld_p1  <= rd_en;
            rd_last_p1 <= last_rd;
        end
    end

    skid_fifo2 #(
        .C_DATA_WIDTH (C_DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_vld  (rd_vld_p1),
        .wr_data (i_cache_data),
        .wr_last (rd_last_p1),
        .rd_rdy  (i_data_ready),
        .rd_vld  (fifo_vld),
        .rd_data (o_data),
        .rd_last (fifo_last),
        .count   (buf_count)
    );

    assign o_cache_addr    = addr;
    assign o_cache_rd_en   = rd_en;
    assign o_data_is_valid = fifo_vld;
    assign o_last          = fifo_vld && fifo_last;
    assign o_busy          = (state != ST_IDLE);
    assign o_done          = done_r;

endmodule

// File: tb/tb_cache_read_streamer.sv
// Directed bench for cache_read_streamer with a 1-cycle-latency cache model.
module tb_cache_read_streamer;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         i_start = 1'b0;
    logic [5:0]   i_base_addr = '0;
    logic [6:0]   i_burst_len = '0;
    logic [5:0]   o_cache_addr;
    logic         o_cache_rd_en;
    logic [127:0] i_cache_data;
    logic         i_cache_empty = 1'b0;
    logic [127:0] o_data;
    logic         o_data_is_valid;
    logic         i_data_ready = 1'b1;
    logic         o_last;
    logic         o_busy;
    logic         o_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [127:0] cache_q = '0;
    logic [127:0] beats[$];
    bit           lasts[$];
    int           beat_cycs[$];
    int           done_cycs[$];
    logic [5:0]   rd_addrs[$];
    int           rd_while_empty = 0;
    int           stab_viol = 0;
    int           occ = 0;
    int           max_occ = 0;
    bit           prev_stall = 0;
    logic [127:0] prev_data = '0;
    logic         prev_last = 1'b0;

    cache_read_streamer #(
        .C_DATA_WIDTH    (128),
        .C_SIZE_OF_CACHE (64)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_start         (i_start),
        .i_base_addr     (i_base_addr),
        .i_burst_len     (i_burst_len),
        .o_cache_addr    (o_cache_addr),
        .o_cache_rd_en   (o_cache_rd_en),
        .i_cache_data    (i_cache_data),
        .i_cache_empty   (i_cache_empty),
        .o_data          (o_data),
        .o_data_is_valid (o_data_is_valid),
        .i_data_ready    (i_data_ready),
        .o_last          (o_last),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cache model: entry i holds value i, returned one cycle after the read strobe.
    always @(posedge clk) if (o_cache_rd_en) cache_q <= 128'(o_cache_addr);
    assign i_cache_data = cache_q;

    // Observer on the falling edge: records reads, beats, done pulses, stalls, occupancy.
    always @(negedge clk) begin
        if (!reset) begin
            occ        = 0;
            prev_stall = 0;
        end else begin
            if (o_cache_rd_en) begin
                rd_addrs.push_back(o_cache_addr);
                if (i_cache_empty) rd_while_empty++;
            end
            if (o_done) done_cycs.push_back(cyc);
            if (prev_stall && (!o_data_is_valid || o_data !== prev_data || o_last !== prev_last))
                stab_viol++;
            if (occ + int'(o_cache_rd_en) > max_occ) max_occ = occ + int'(o_cache_rd_en);
            if (o_data_is_valid && i_data_ready) begin
                beats.push_back(o_data);
                lasts.push_back(o_last);
                beat_cycs.push_back(cyc);
            end
            occ = occ + int'(o_cache_rd_en) - int'(o_data_is_valid && i_data_ready);
            prev_stall = o_data_is_valid && !i_data_ready;
            prev_data  = o_data;
            prev_last  = o_last;
        end
    end

    task automatic run_burst(input logic [5:0] base, input logic [6:0] len, input bit toggle,
                             input int es, input int el, input bit restart_mid,
                             output int start_cyc, output bit timed_out);
        int d0;
        d0 = done_cycs.size();
        @(posedge clk); #1;
        i_base_addr = base;
        i_burst_len = len;
        i_start     = 1'b1;
        start_cyc   = cyc;
        timed_out   = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            i_start = restart_mid && (c == 3);
            if (restart_mid && c == 3) begin
                i_base_addr = 6'd40;
                i_burst_len = 7'd3;
            end
            i_data_ready  = toggle ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
            i_cache_empty = (c >= es) && (c < es + el);
            if (done_cycs.size() > d0) begin
                timed_out = 1'b0;
                break;
            end
        end
        i_start       = 1'b0;
        i_data_ready  = 1'b1;
        i_cache_empty = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (o_cache_addr !== 6'd0) begin n_fail++; $display("FAIL rst_addr got %0h want 0", o_cache_addr); end
        n_tests++; if (o_cache_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en got %b want 0", o_cache_rd_en); end
        n_tests++; if (o_data !== 128'd0) begin n_fail++; $display("FAIL rst_data got %0h want 0", o_data); end
        n_tests++; if (o_data_is_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", o_data_is_valid); end
        n_tests++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL rst_last got %b want 0", o_last); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", o_busy); end
        n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", o_done); end
        reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        int b0, d0, sc;
        bit to;
        b0 = beats.size();
        d0 = done_cycs.size();
        run_burst(6'd0, 7'd4, 0, 1000, 0, 0, sc, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL basic_timeout got timeout want done"); end
        n_tests++; if (beats.size() - b0 != 4) begin n_fail++; $display("FAIL basic_count got %0d want 4", beats.size() - b0); end
        for (int i = 0; i < 4 && b0 + i < beats.size(); i++) begin
            n_tests++; if (beats[b0+i] !== 128'(i)) begin n_fail++; $display("FAIL basic_beat%0d got %0h want %0h", i, beats[b0+i], i); end
            n_tests++; if (lasts[b0+i] !== (i == 3)) begin n_fail++; $display("FAIL basic_last%0d got %b want %b", i, lasts[b0+i], i == 3); end
        end
        if (beats.size() > b0) begin
            n_tests++; if (beat_cycs[b0] - sc != 2) begin n_fail++; $display("FAIL basic_latency got %0d want 2", beat_cycs[b0] - sc); end
        end
        n_tests++; if (done_cycs.size() - d0 != 1) begin n_fail++; $display("FAIL basic_done_cnt got %0d want 1", done_cycs.size() - d0); end
        if (done_cycs.size() > d0 && beats.size() > b0) begin
            n_tests++;
            if (done_cycs[d0] - beat_cycs[beats.size()-1] != 1) begin
                n_fail++; $display("FAIL basic_done_time got %0d want 1", done_cycs[d0] - beat_cycs[beats.size()-1]);
            end
        end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b want 0", o_busy); end
    endtask

    task automatic test_wrap();
        int b0, r0, sc;
        bit to;
        logic [5:0] exp_a [4];
        exp_a = '{6'd62, 6'd63, 6'd0, 6'd1};
        b0 = beats.size();
        r0 = rd_addrs.size();
        run_burst(6'd62, 7'd4, 0, 1000, 0, 0, sc, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL wrap_timeout got timeout want done"); end
        n_tests++; if (rd_addrs.size() - r0 != 4) begin n_fail++; $display("FAIL wrap_reads got %0d want 4", rd_addrs.size() - r0); end
        for (int i = 0; i < 4; i++) begin
            if (r0 + i < rd_addrs.size()) begin
                n_tests++; if (rd_addrs[r0+i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_addr%0d got %0d want %0d", i, rd_addrs[r0+i], exp_a[i]); end
            end
            if (b0 + i < beats.size()) begin
                n_tests++; if (beats[b0+i] !== 128'(exp_a[i])) begin n_fail++; $display("FAIL wrap_beat%0d got %0h want %0h", i, beats[b0+i], exp_a[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int b0, s0, sc;
        bit to;
        b0 = beats.size();
        s0 = stab_viol;
        run_burst(6'd5, 7'd8, 1, 1000, 0, 1, sc, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL bp_timeout got timeout want done"); end
        n_tests++; if (beats.size() - b0 != 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", beats.size() - b0); end
        for (int i = 0; i < 8 && b0 + i < beats.size(); i++) begin
            n_tests++; if (beats[b0+i] !== 128'(5 + i)) begin n_fail++; $display("FAIL bp_beat%0d got %0h want %0h", i, beats[b0+i], 5 + i); end
        end
        n_tests++; if (stab_viol != s0) begin n_fail++; $display("FAIL bp_stable got %0d violations want 0", stab_viol - s0); end
        n_tests++; if (max_occ > 2) begin n_fail++; $display("FAIL bp_occupancy got %0d want <=2", max_occ); end
    endtask

    task automatic test_zero_len();
        int r0, d0, sc;
        bit to;
        r0 = rd_addrs.size();
        d0 = done_cycs.size();
        run_burst(6'd7, 7'd0, 0, 1000, 0, 0, sc, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL zero_timeout got timeout want done"); end
        n_tests++; if (rd_addrs.size() != r0) begin n_fail++; $display("FAIL zero_reads got %0d want 0", rd_addrs.size() - r0); end
        if (done_cycs.size() > d0) begin
            n_tests++; if (done_cycs[d0] - sc != 1) begin n_fail++; $display("FAIL zero_done_time got %0d want 1", done_cycs[d0] - sc); end
        end
        repeat (2) @(posedge clk);
        n_tests++; if (done_cycs.size() - d0 != 1) begin n_fail++; $display("FAIL zero_done_cnt got %0d want 1", done_cycs.size() - d0); end
    endtask

    task automatic test_clamp();
        int b0, r0, bad, sc;
        bit to;
        b0 = beats.size();
        r0 = rd_addrs.size();
        bad = 0;
        run_burst(6'd0, 7'd100, 0, 1000, 0, 0, sc, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL clamp_timeout got timeout want done"); end
        n_tests++; if (beats.size() - b0 != 64) begin n_fail++; $display("FAIL clamp_count got %0d want 64", beats.size() - b0); end
        n_tests++; if (rd_addrs.size() - r0 != 64) begin n_fail++; $display("FAIL clamp_reads got %0d want 64", rd_addrs.size() - r0); end
        for (int i = 0; i < 64 && b0 + i < beats.size(); i++)
            if (beats[b0+i] !== 128'(i)) bad++;
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL clamp_order got %0d wrong beats want 0", bad); end
    endtask

    task automatic test_cache_empty();
        int b0, r0, e0, sc;
        bit to;
        b0 = beats.size();
        r0 = rd_addrs.size();
        e0 = rd_while_empty;
        run_burst(6'd3, 7'd6, 0, 2, 5, 0, sc, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL empty_timeout got timeout want done"); end
        n_tests++; if (rd_while_empty != e0) begin n_fail++; $display("FAIL empty_rd_en got %0d reads want 0", rd_while_empty - e0); end
        n_tests++; if (rd_addrs.size() - r0 != 6) begin n_fail++; $display("FAIL empty_reads got %0d want 6", rd_addrs.size() - r0); end
        n_tests++; if (beats.size() - b0 != 6) begin n_fail++; $display("FAIL empty_count got %0d want 6", beats.size() - b0); end
        for (int i = 0; i < 6 && b0 + i < beats.size(); i++) begin
            n_tests++; if (beats[b0+i] !== 128'(3 + i)) begin n_fail++; $display("FAIL empty_beat%0d got %0h want %0h", i, beats[b0+i], 3 + i); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int b0, d0, b_rst, sc;
        bit to;
        b0 = beats.size();
        @(posedge clk); #1;
        i_base_addr = 6'd10;
        i_burst_len = 7'd8;
        i_start     = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int c = 0; c < 50 && beats.size() - b0 < 2; c++) begin
            @(posedge clk); #1;
        end
        n_tests++; if (beats.size() - b0 < 2) begin n_fail++; $display("FAIL rmid_pre_beats got %0d want >=2", beats.size() - b0); end
        reset = 1'b0;
        d0    = done_cycs.size();
        b_rst = beats.size();
        @(posedge clk); #1;
        reset = 1'b1;
        n_tests++; if (o_data_is_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", o_data_is_valid); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", o_busy); end
        n_tests++; if (o_cache_addr !== 6'd0) begin n_fail++; $display("FAIL rmid_addr got %0d want 0", o_cache_addr); end
        repeat (5) @(posedge clk);
        #1;
        n_tests++; if (done_cycs.size() != d0) begin n_fail++; $display("FAIL rmid_no_done got %0d pulses want 0", done_cycs.size() - d0); end
        n_tests++; if (beats.size() != b_rst) begin n_fail++; $display("FAIL rmid_stray_beats got %0d want 0", beats.size() - b_rst); end
        run_burst(6'd20, 7'd2, 0, 1000, 0, 0, sc, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL rmid_timeout got timeout want done"); end
        n_tests++; if (beats.size() - b_rst != 2) begin n_fail++; $display("FAIL rmid_count got %0d want 2", beats.size() - b_rst); end
        for (int i = 0; i < 2 && b_rst + i < beats.size(); i++) begin
            n_tests++; if (beats[b_rst+i] !== 128'(20 + i)) begin n_fail++; $display("FAIL rmid_beat%0d got %0h want %0h", i, beats[b_rst+i], 20 + i); end
            n_tests++; if (lasts[b_rst+i] !== (i == 1)) begin n_fail++; $display("FAIL rmid_last%0d got %b want %b", i, lasts[b_rst+i], i == 1); end
        end
        n_tests++; if (done_cycs.size() - d0 != 1) begin n_fail++; $display("FAIL rmid_done_cnt got %0d want 1", done_cycs.size() - d0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_clamp();
        test_cache_empty();
        test_reset_mid_burst();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
